// File: rtl/sram_queue_pkg.sv
// sram_queue_pkg: sizes, entry type and obuf pointer helper
// shared by the SRAM-backed queue controller and its output buffer.
package sram_queue_pkg;

    localparam int DEPTH    = 64;
    localparam int WIDTH    = 420;
    localparam int ADDR_W   = 6;
    localparam int OB_DEPTH = 3;
    localparam int CNT_W    = 7;
    localparam int MCNT_W   = ADDR_W + 1;
    localparam int OBC_W    = 2;

    typedef logic [WIDTH-1:0] entry_t;
    typedef logic [OBC_W-1:0] ob_ptr_t;

    function automatic ob_ptr_t ob_next(input ob_ptr_t p);
        return (p == ob_ptr_t'(OB_DEPTH - 1)) ? '0 : p + ob_ptr_t'(1);
    endfunction

endpackage

// File: rtl/sram_queue_obuf.sv
// sram_queue_obuf: 3-entry register FIFO holding entries already read
// from the array, so the consumer sees registered data at full rate.
module sram_queue_obuf
    import sram_queue_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [OBC_W-1:0] count
);

    entry_t  slot [OB_DEPTH];
    ob_ptr_t head;
    ob_ptr_t tail;

    assign head_data = slot[head];

    always_ff @(posedge clock) begin
        if (push) begin
            slot[tail] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= ob_next(tail);
            end
            if (pop) begin
                head <= ob_next(head);
            end
            case ({push, pop})
                2'b10:   count <= count + OBC_W'(1);
                2'b01:   count <= count - OBC_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_queue_ctrl.sv
// sram_queue_ctrl: ready/valid FIFO over a 1R1W array (1-cycle read latency).
// Define SRAM_QUEUE_BYPASS_EN to let enqueues into an idle queue skip the array.
module sram_queue_ctrl
    import sram_queue_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              io_enq_valid,
    output logic              io_enq_ready,
    input  logic [WIDTH-1:0]  io_enq_bits,
    output logic              io_deq_valid,
    input  logic              io_deq_ready,
    output logic [WIDTH-1:0]  io_deq_bits,
    output logic [CNT_W-1:0]  io_count,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic              mem_wen,
    output logic [WIDTH-1:0]  mem_wdata,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic              mem_ren,
    input  logic [WIDTH-1:0]  mem_rdata
);

    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic [MCNT_W-1:0] mem_cnt;
    logic              inflight;
    logic [OBC_W-1:0]  ob_cnt;
    logic [OBC_W:0]    ob_claimed;
    logic              enq_fire;
    logic              deq_fire;
    logic              bypass;
    logic              ob_push;
    logic [WIDTH-1:0]  ob_push_data;

    assign io_enq_ready = !reset && (mem_cnt != MCNT_W'(DEPTH));
    assign enq_fire     = io_enq_valid && io_enq_ready;

`ifdef SRAM_QUEUE_BYPASS_EN
    assign bypass = enq_fire && (mem_cnt == '0) && !inflight
                 && (ob_cnt != OBC_W'(OB_DEPTH));
`else
    assign bypass = 1'b0;
`endif

    assign mem_wen   = enq_fire && !bypass;
    assign mem_waddr = wptr;
    assign mem_wdata = io_enq_bits;

    // An outstanding read already owns an obuf slot when it lands.
    assign ob_claimed = {1'b0, ob_cnt} + {{OBC_W{1'b0}}, inflight};
    assign mem_ren    = !reset && (mem_cnt != '0)
                     && (ob_claimed < (OBC_W+1)'(OB_DEPTH));
    assign mem_raddr  = rptr;

    assign ob_push      = !reset && (inflight || bypass);
    assign ob_push_data = inflight ? mem_rdata : io_enq_bits;
    assign io_deq_valid = !reset && (ob_cnt != '0);
    assign deq_fire     = io_deq_valid && io_deq_ready;

    assign io_count = reset ? '0
                    : CNT_W'(mem_cnt) + CNT_W'(inflight) + CNT_W'(ob_cnt);

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            mem_cnt  <= '0;
            inflight <= 1'b0;
        end else begin
            if (mem_wen) begin
                wptr <= wptr + ADDR_W'(1);
            end
            if (mem_ren) begin
                rptr <= rptr + ADDR_W'(1);
            end
            inflight <= mem_ren;
            case ({mem_wen, mem_ren})
                2'b10:   mem_cnt <= mem_cnt + MCNT_W'(1);
                2'b01:   mem_cnt <= mem_cnt - MCNT_W'(1);
                default: mem_cnt <= mem_cnt;
            endcase
        end
    end

    sram_queue_obuf u_obuf (
        .clock     (clock),
        .reset     (reset),
        .push      (ob_push),
        .push_data (ob_push_data),
        .pop       (deq_fire),
        .head_data (io_deq_bits),
        .count     (ob_cnt)
    );

endmodule

// File: tb/tb_sram_queue_ctrl.sv
// tb_sram_queue_ctrl: directed checks of the SRAM-backed queue controller
// with a behavioural 1-cycle-latency array model.
module tb_sram_queue_ctrl;
    import sram_queue_pkg::*;

`ifdef SRAM_QUEUE_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 3;
`endif

    logic              clock = 1'b0;
    logic              reset;
    logic              io_enq_valid;
    logic              io_enq_ready;
    logic [WIDTH-1:0]  io_enq_bits;
    logic              io_deq_valid;
    logic              io_deq_ready;
    logic [WIDTH-1:0]  io_deq_bits;
    logic [CNT_W-1:0]  io_count;
    logic [ADDR_W-1:0] mem_waddr;
    logic              mem_wen;
    logic [WIDTH-1:0]  mem_wdata;
    logic [ADDR_W-1:0] mem_raddr;
    logic              mem_ren;
    logic [WIDTH-1:0]  mem_rdata;

    int errors = 0;
    int checks = 0;
    int stall;
    int nxt;
    int mcnt_m = 0;
    int ren_viol = 0;
    entry_t sb[$];

    always #5 clock = ~clock;

    sram_queue_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .io_enq_valid (io_enq_valid),
        .io_enq_ready (io_enq_ready),
        .io_enq_bits  (io_enq_bits),
        .io_deq_valid (io_deq_valid),
        .io_deq_ready (io_deq_ready),
        .io_deq_bits  (io_deq_bits),
        .io_count     (io_count),
        .mem_waddr    (mem_waddr),
        .mem_wen      (mem_wen),
        .mem_wdata    (mem_wdata),
        .mem_raddr    (mem_raddr),
        .mem_ren      (mem_ren),
        .mem_rdata    (mem_rdata)
    );

    entry_t sram [DEPTH];
    entry_t rdata_q;

    always @(posedge clock) begin
        if (mem_wen) sram[mem_waddr] <= mem_wdata;
        if (mem_ren) rdata_q <= sram[mem_raddr];
    end
    assign mem_rdata = rdata_q;

    // Array occupancy seen from the ports; io_count minus this is obuf+inflight.
    always @(posedge clock) begin
        if (reset) mcnt_m <= 0;
        else mcnt_m <= mcnt_m + int'(mem_wen) - int'(mem_ren);
    end

    always @(negedge clock) begin
        if (!reset && mem_ren
            && ((int'(io_count) - mcnt_m >= OB_DEPTH) || mcnt_m == 0))
            ren_viol++;
    end

    task automatic check(input string tag,
                         input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        io_enq_valid = 1'b1;
        io_enq_bits = '0;
        io_deq_ready = 1'b0;
        repeat (2) begin
            mid();
            check("rst_enq_ready", io_enq_ready, 0);
            check("rst_deq_valid", io_deq_valid, 0);
            check("rst_count", io_count, 0);
            check("rst_wen", mem_wen, 0);
            check("rst_ren", mem_ren, 0);
            tick();
        end

        // single entry latency
        reset = 1'b0;
        io_enq_bits = WIDTH'(32'h5A);
        mid();
        check("t1_wen", mem_wen, (LAT == 3));
        check("t1_waddr", mem_waddr, 0);
        check("t1_wdata", mem_wdata, 32'h5A);
        check("t1_count0", io_count, 0);
        tick();
        io_enq_valid = 1'b0;
        mid();
        check("t1_ren", mem_ren, (LAT == 3));
        check("t1_raddr", mem_raddr, 0);
        check("t1_count1", io_count, 1);
        check("t1_valid1", io_deq_valid, (LAT == 1));
        tick();
        mid();
        check("t1_count2", io_count, 1);
        check("t1_valid2", io_deq_valid, (LAT == 1));
        tick();
        io_deq_ready = 1'b1;
        mid();
        check("t1_valid3", io_deq_valid, 1);
        check("t1_bits3", io_deq_bits, 32'h5A);
        check("t1_count3", io_count, 1);
        tick();
        io_deq_ready = 1'b0;
        mid();
        check("t1_empty_count", io_count, 0);
        check("t1_empty_valid", io_deq_valid, 0);
        tick();

        // fill to DEPTH+3
        stall = 0;
        io_enq_valid = 1'b1;
        for (int i = 0; i < 67; i++) begin
            io_enq_bits = WIDTH'(100 + i);
            mid();
            if (!io_enq_ready) stall++;
            tick();
        end
        check("fill_no_stall", stall, 0);
        io_enq_bits = WIDTH'(999);
        mid();
        check("full_enq_ready", io_enq_ready, 0);
        check("full_wen", mem_wen, 0);
        check("full_count", io_count, 67);
        check("full_ren", mem_ren, 0);
        tick();
        io_enq_valid = 1'b0;

        io_deq_ready = 1'b1;
        for (int i = 0; i < 67; i++) begin
            mid();
            check("drain_valid", io_deq_valid, 1);
            check("drain_bits", io_deq_bits, WIDTH'(100 + i));
            if (i < 2) check("drain_enq_ready_full", io_enq_ready, 0);
            if (i == 2) check("drain_enq_ready_reopen", io_enq_ready, 1);
            tick();
        end
        mid();
        check("drain_count", io_count, 0);
        check("drain_valid_end", io_deq_valid, 0);
        tick();

        // streaming, pointers wrap past 63
        io_enq_valid = 1'b1;
        for (int c = 0; c < 200; c++) begin
            io_enq_bits = WIDTH'(1000 + c);
            mid();
            check("stream_enq_ready", io_enq_ready, 1);
            if (c >= LAT) begin
                check("stream_valid", io_deq_valid, 1);
                check("stream_bits", io_deq_bits, WIDTH'(1000 + c - LAT));
            end else begin
                check("stream_prefill", io_deq_valid, 0);
            end
            tick();
        end
        io_enq_valid = 1'b0;
        for (int c = 0; c < LAT; c++) begin
            mid();
            check("stream_tail_valid", io_deq_valid, 1);
            check("stream_tail_bits", io_deq_bits, WIDTH'(1200 - LAT + c));
            tick();
        end
        mid();
        check("stream_empty", io_count, 0);
        tick();

        // random consumer backpressure against a scoreboard
        nxt = 5000;
        io_enq_valid = 1'b1;
        for (int c = 0; c < 400; c++) begin
            io_enq_bits = WIDTH'(nxt);
            io_deq_ready = 1'($urandom_range(0, 1));
            mid();
            check("rand_count", io_count, sb.size());
            if (io_deq_valid && io_deq_ready) begin
                if (sb.size() == 0) check("rand_extra_deq", io_deq_valid, 0);
                else check("rand_order", io_deq_bits, sb.pop_front());
            end
            if (io_enq_ready) begin
                sb.push_back(WIDTH'(nxt));
                nxt++;
            end
            tick();
        end
        io_enq_valid = 1'b0;
        io_deq_ready = 1'b1;
        for (int c = 0; c < 100 && sb.size() > 0; c++) begin
            mid();
            if (io_deq_valid) check("rand_drain_order", io_deq_bits, sb.pop_front());
            tick();
        end
        check("rand_drained", sb.size(), 0);
        mid();
        check("rand_final_count", io_count, 0);
        tick();

        // reset while a read is in flight
        io_deq_ready = 1'b0;
        io_enq_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            io_enq_bits = WIDTH'(600 + i);
            tick();
        end
        io_enq_bits = WIDTH'(605);
        io_deq_ready = 1'b1;
        mid();
        check("mr_count_pre", io_count, 5);
        check("mr_head", io_deq_bits, WIDTH'(600));
        tick();
        io_enq_valid = 1'b0;
        io_deq_ready = 1'b0;
        mid();
        check("mr_count_issue", io_count, 5);
        check("mr_ren_issue", mem_ren, 1);
        tick();
        reset = 1'b1;
        mid();
        check("mr_rst_count", io_count, 0);
        check("mr_rst_valid", io_deq_valid, 0);
        check("mr_rst_enq_ready", io_enq_ready, 0);
        check("mr_rst_ren", mem_ren, 0);
        tick();
        reset = 1'b0;
        io_enq_valid = 1'b1;
        io_enq_bits = WIDTH'(32'h77);
        mid();
        check("mr_post_count", io_count, 0);
        check("mr_post_valid", io_deq_valid, 0);
        check("mr_post_enq_ready", io_enq_ready, 1);
        tick();
        io_enq_valid = 1'b0;
        for (int c = 1; c < LAT; c++) begin
            mid();
            check("mr_no_stale", io_deq_valid, 0);
            tick();
        end
        mid();
        check("mr_new_valid", io_deq_valid, 1);
        check("mr_new_bits", io_deq_bits, 32'h77);
        check("mr_new_count", io_count, 1);
        io_deq_ready = 1'b1;
        tick();
        io_deq_ready = 1'b0;
        mid();
        check("mr_end_count", io_count, 0);
        tick();

`ifdef SRAM_QUEUE_BYPASS_EN
        io_enq_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            io_enq_bits = WIDTH'(700 + i);
            mid();
            check("byp_wen", mem_wen, 0);
            check("byp_valid", io_deq_valid, (i != 0));
            tick();
        end
        io_enq_bits = WIDTH'(703);
        mid();
        check("byp_full_ob_wen", mem_wen, 1);
        check("byp_head", io_deq_bits, WIDTH'(700));
        tick();
        io_enq_valid = 1'b0;
`endif

        check("ren_rule_violations", ren_viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
